axrm_err_monitor: RTL and testbench
===================================

AXRM_ERR_MONITOR -- requirements
Module: axrm_err_monitor

Interface
REQ-001 Parameter WIDTH, default 16: operand width of the upstream approximate multiplier.
REQ-002 Parameter CNT_W, default 20: width of the sample and error counters.
REQ-003 Parameter ACC_W, default 2*WIDTH+CNT_W: width of the error-distance accumulator.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: one-cycle pulse that begins a measurement run.
REQ-008 Port num_samples, input, CNT_W: samples per run; latched on an accepted start.
REQ-009 Port in_valid, input, 1: in_a, in_b and in_approx are valid this cycle.
REQ-010 Port in_ready, output, 1: the block accepts a sample this cycle.
REQ-011 Port in_a, input, WIDTH: multiplicand applied to the multiplier.
REQ-012 Port in_b, input, WIDTH: multiplier operand applied to the multiplier.
REQ-013 Port in_approx, input, 2*WIDTH: approximate product returned by the multiplier.
REQ-014 Port busy, output, 1: high in RUN and DRAIN.
REQ-015 Port done, output, 1: level signal, high in DONE.
REQ-016 Port sample_cnt, output, CNT_W: samples accepted in the current run.
REQ-017 Port err_cnt, output, CNT_W: samples with a nonzero error distance.
REQ-018 Port sum_ed, output, ACC_W: sum of error distances.
REQ-019 Port max_ed, output, 2*WIDTH: largest error distance seen.
REQ-020 Ports max_a and max_b, output, WIDTH each: operands that produced max_ed.

Function
REQ-021 FSM states and transitions SHALL be:
- IDLE -> RUN on start.
- RUN -> DRAIN once sample_cnt equals the latched num_samples.
- DRAIN -> DONE once the pipeline is empty.
- DONE -> RUN on start.
REQ-022 start in IDLE or DONE SHALL, in the same edge, clear all statistics outputs, latch num_samples and enter RUN; start in RUN or DRAIN SHALL be ignored.
REQ-023 in_ready SHALL be high only in RUN while sample_cnt is below the latched num_samples; a sample is accepted when in_valid and in_ready are both high.
REQ-024 An accepted sample SHALL increment sample_cnt on the acceptance edge.
REQ-025 Datapath pipeline:
- Stage 1 registers in_a, in_b and in_approx.
- Stage 2 registers the exact product in_a*in_b (2*WIDTH bits) and the approximate product.
- The accumulators update on the next edge, so sum_ed, err_cnt and max_ed reflect a sample 3 edges after acceptance.
REQ-026 Error distance SHALL be |exact - approx|, computed with a (2*WIDTH+1)-bit signed difference and returned as an unsigned 2*WIDTH-bit value; approx > exact is legal.
REQ-027 err_cnt SHALL increment when the error distance is nonzero; sum_ed SHALL add the error distance zero-extended to ACC_W and never wraps for num_samples <= 2^CNT_W-1.
REQ-028 max_ed, max_a and max_b SHALL update only when the error distance is strictly greater than max_ed, so the first occurrence wins a tie.
REQ-029 With num_samples=0, RUN SHALL pass to DRAIN on the next edge and then to DONE; in_ready never goes high and all statistics stay 0.
REQ-030 Statistics SHALL hold stable in DONE until the next accepted start.

Reset
REQ-031 rst_n low SHALL, asynchronously:
- force IDLE;
- clear the pipeline valid flags, counters, accumulators and max registers to 0;
- drive in_ready, busy and done low.
REQ-032 Reset asserted mid-run SHALL discard in-flight samples; the next start after release SHALL behave as a fresh run.

Structure
REQ-033 Package axrm_pkg SHALL hold the WIDTH, CNT_W and ACC_W defaults and the FSM state enum (IDLE, RUN, DRAIN, DONE).
REQ-034 Sub-module axrm_err_dist SHALL be the combinational absolute-difference unit; the exact product SHALL be inferred in-line.

Verification
REQ-035 num_samples=3 with samples (3,5,15), (255,255,65025), (0,7,0) -> done; sample_cnt=3, err_cnt=0, sum_ed=0, max_ed=0.
REQ-036 num_samples=2 with samples (0x00FF,0x00FF,65000) and (2,3,10) -> sum_ed=29, err_cnt=2, max_ed=25, max_a=max_b=0x00FF.
REQ-037 num_samples=2 where both samples have error distance 4, first (1,4,0) then (2,2,0) -> max_a=1, max_b=4 (tie keeps the first).
REQ-038 num_samples=0, pulse start -> done within 3 cycles, in_ready never high, all statistics 0.
REQ-039 num_samples=4: assert rst_n low after 2 acceptances -> all outputs 0 immediately; a new start with 1 sample yields sample_cnt=1.
REQ-040 Gapped in_valid, with in_valid held after the count is reached -> in_ready low, no extra sample counted, start during RUN ignored.

Source files
------------

// File: rtl/axrm_pkg.sv
// Shared defaults and FSM state encoding for the approximate-multiplier error monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axrm_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 20;
  localparam int DEF_ACC_W = 2 * DEF_WIDTH + DEF_CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/axrm_err_monitor_if.sv
// Sample stream from the multiplier harness: operands plus the approximate product.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a sample moves when in_valid and in_ready are both high.
interface axrm_err_monitor_if
  import axrm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2*WIDTH-1:0] in_approx;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_approx,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_approx,
    output in_ready
  );

endinterface

// File: rtl/axrm_err_dist.sv
// Absolute difference between exact and approximate products (error distance).
// Latency: combinational.
// Backpressure: none.
module axrm_err_dist
  import axrm_pkg::*;
#(
  parameter int PW = 2 * DEF_WIDTH
) (
  input  logic [PW-1:0] exact_i,
  input  logic [PW-1:0] approx_i,
  output logic [PW-1:0] ed_o,
  output logic          nz_o
);

  // One extra bit keeps approx > exact representable as a negative difference.
  logic signed [PW:0] diff_w;

  assign diff_w = $signed({1'b0, exact_i}) - $signed({1'b0, approx_i});
  // Magnitude never exceeds 2^PW-1, so dropping the sign bit after negation is lossless.
  assign ed_o   = diff_w[PW] ? PW'(-diff_w) : PW'(diff_w);
  assign nz_o   = |diff_w;

endmodule

// File: rtl/axrm_err_monitor.sv
// Measures error statistics (count, sum, max) of an approximate multiplier over a run.
// Latency: statistics reflect a sample 3 edges after acceptance; done follows pipeline drain.
// Backpressure: in_ready high only in RUN until the latched sample count is reached.
module axrm_err_monitor
  import axrm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = 2 * WIDTH + CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  axrm_err_monitor_if.slave  smp,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*WIDTH-1:0] max_ed,
  output logic [WIDTH-1:0]   max_a,
  output logic [WIDTH-1:0]   max_b
);

  localparam int PW = 2 * WIDTH;

  state_e state_q, state_d;

  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [ACC_W-1:0] sum_ed_q;
  logic [PW-1:0]    max_ed_q;
  logic [WIDTH-1:0] max_a_q, max_b_q;

  // Stage 1: raw sample
  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [PW-1:0]    s1_apx_q;

  // Stage 2: exact and approximate products, operands kept for max tracking
  logic             s2_vld_q;
  logic [WIDTH-1:0] s2_a_q, s2_b_q;
  logic [PW-1:0]    s2_exact_q;
  logic [PW-1:0]    s2_apx_q;

  logic          start_ok_w;
  logic          accept_w;
  logic          in_ready_w;
  logic          pipe_empty_w;
  logic [PW-1:0] prod_w;
  logic [PW-1:0] ed_w;
  logic          ed_nz_w;

  // A start is only honoured between runs; during RUN/DRAIN it is dropped.
  assign start_ok_w   = start && ((state_q == IDLE) || (state_q == DONE));
  assign accept_w     = smp.in_valid && in_ready_w;
  assign pipe_empty_w = !s1_vld_q && !s2_vld_q;
  assign prod_w       = PW'(s1_a_q) * PW'(s1_b_q);

  axrm_err_dist #(
    .PW (PW)
  ) u_err_dist (
    .exact_i  (s2_exact_q),
    .approx_i (s2_apx_q),
    .ed_o     (ed_w),
    .nz_o     (ed_nz_w)
  );

  // Next-state selection and per-state status outputs.
  always_comb begin
    state_d    = state_q;
    in_ready_w = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        in_ready_w = (sample_cnt_q < num_q);
        if (sample_cnt_q == num_q) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pipe_empty_w) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Run length latch and accepted-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q        <= '0;
      sample_cnt_q <= '0;
    end else if (start_ok_w) begin
      num_q        <= num_samples;
      sample_cnt_q <= '0;
    end else if (accept_w) begin
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
    end
  end

  // Two-stage datapath pipeline: capture sample, then form the exact product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_apx_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_exact_q <= '0;
      s2_apx_q   <= '0;
    end else begin
      s1_vld_q <= accept_w;
      s2_vld_q <= s1_vld_q;
      if (accept_w) begin
        s1_a_q   <= smp.in_a;
        s1_b_q   <= smp.in_b;
        s1_apx_q <= smp.in_approx;
      end
      if (s1_vld_q) begin
        s2_a_q     <= s1_a_q;
        s2_b_q     <= s1_b_q;
        s2_exact_q <= prod_w;
        s2_apx_q   <= s1_apx_q;
      end
    end
  end

  // Statistics accumulate from stage 2; strict compare keeps the first maximum on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      sum_ed_q  <= '0;
      max_ed_q  <= '0;
      max_a_q   <= '0;
      max_b_q   <= '0;
    end else if (start_ok_w) begin
      err_cnt_q <= '0;
      sum_ed_q  <= '0;
      max_ed_q  <= '0;
      max_a_q   <= '0;
      max_b_q   <= '0;
    end else if (s2_vld_q) begin
      if (ed_nz_w) err_cnt_q <= err_cnt_q + CNT_W'(1);
      sum_ed_q <= sum_ed_q + ACC_W'(ed_w);
      if (ed_w > max_ed_q) begin
        max_ed_q <= ed_w;
        max_a_q  <= s2_a_q;
        max_b_q  <= s2_b_q;
      end
    end
  end

  assign smp.in_ready = in_ready_w;
  assign sample_cnt   = sample_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign sum_ed       = sum_ed_q;
  assign max_ed       = max_ed_q;
  assign max_a        = max_a_q;
  assign max_b        = max_b_q;

endmodule

// File: tb/tb_axrm_err_monitor.sv
// Scoreboard bench: each run pushes its expected statistics; a monitor pops on done rising.
// Latency: n/a.
// Backpressure: driver holds in_valid until in_ready is seen.
module tb_axrm_err_monitor;

  localparam int WIDTH = 16;
  localparam int CNT_W = 20;
  localparam int ACC_W = 2 * WIDTH + CNT_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   num_samples = '0;
  logic               busy, done;
  logic [CNT_W-1:0]   sample_cnt, err_cnt;
  logic [ACC_W-1:0]   sum_ed;
  logic [2*WIDTH-1:0] max_ed;
  logic [WIDTH-1:0]   max_a, max_b;

  axrm_err_monitor_if #(.WIDTH(WIDTH)) smp ();

  axrm_err_monitor #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .smp         (smp),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed),
    .max_a       (max_a),
    .max_b       (max_b)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   err;
    logic [ACC_W-1:0]   sum;
    logic [2*WIDTH-1:0] mx;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
  } exp_t;

  exp_t sb[$];
  logic done_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int cnt, input int err, input int sum,
                          input int mx, input int ma, input int mb);
    exp_t e;
    e.cnt = CNT_W'(cnt);
    e.err = CNT_W'(err);
    e.sum = ACC_W'(sum);
    e.mx  = (2*WIDTH)'(mx);
    e.ma  = WIDTH'(ma);
    e.mb  = WIDTH'(mb);
    sb.push_back(e);
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    num_samples = CNT_W'(n);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int apx);
    bit ok = 1'b0;
    @(negedge clk);
    smp.in_valid  = 1'b1;
    smp.in_a      = WIDTH'(a);
    smp.in_b      = WIDTH'(b);
    smp.in_approx = (2*WIDTH)'(apx);
    for (int i = 0; i < 50; i++) begin
      if (smp.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    smp.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done_timeout actual=done_low required=done_high", tag);
    end
  endtask

  // Monitor: compare final statistics against the scoreboard each time done rises.
  initial begin
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done_rise required=no_pending_run");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_sample_cnt", 64'(sample_cnt), 64'(e.cnt));
          chk("sb_err_cnt",    64'(err_cnt),    64'(e.err));
          chk("sb_sum_ed",     64'(sum_ed),     64'(e.sum));
          chk("sb_max_ed",     64'(max_ed),     64'(e.mx));
          chk("sb_max_a",      64'(max_a),      64'(e.ma));
          chk("sb_max_b",      64'(max_b),      64'(e.mb));
        end
      end
      done_prev = done;
    end
  end

  // Directed stimulus.
  initial begin
    bit rdy_seen;
    smp.in_valid  = 1'b0;
    smp.in_a      = '0;
    smp.in_b      = '0;
    smp.in_approx = '0;

    // Reset state
    idle(2);
    chk("rst_in_ready",   64'(smp.in_ready), 64'd0);
    chk("rst_busy",       64'(busy),         64'd0);
    chk("rst_done",       64'(done),         64'd0);
    chk("rst_sample_cnt", 64'(sample_cnt),   64'd0);
    chk("rst_sum_ed",     64'(sum_ed),       64'd0);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_busy",  64'(busy),         64'd0);

    // Exact products only: no error
    push_exp(3, 0, 0, 0, 0, 0);
    start_run(3);
    send(3, 5, 15);
    send(255, 255, 65025);
    send(0, 7, 0);
    wait_done("exact");

    // Error distances 25 and 4 (approx above exact on the second); latency probe on the first
    push_exp(2, 2, 29, 25, 16'h00FF, 16'h00FF);
    start_run(2);
    chk("restart_clears_sum", 64'(sum_ed), 64'd0);
    send(16'h00FF, 16'h00FF, 65000);
    idle(1);
    chk("lat_edge1_sum", 64'(sum_ed), 64'd0);
    idle(1);
    chk("lat_edge2_sum", 64'(sum_ed), 64'd0);
    idle(1);
    chk("lat_edge3_sum", 64'(sum_ed), 64'd25);
    send(2, 3, 10);
    wait_done("mixed");

    // Tie on max: first occurrence kept
    push_exp(2, 2, 8, 4, 1, 4);
    start_run(2);
    send(1, 4, 0);
    send(2, 2, 0);
    wait_done("tie");

    // Zero-length run
    push_exp(0, 0, 0, 0, 0, 0);
    start_run(0);
    rdy_seen = smp.in_ready;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (smp.in_ready) rdy_seen = 1'b1;
    end
    chk("zero_in_ready_never", 64'(rdy_seen), 64'd0);
    chk("zero_done_in_3",      64'(done),     64'd1);
    chk("zero_busy_low",       64'(busy),     64'd0);

    // Reset mid-run discards state, then a fresh 1-sample run
    start_run(4);
    send(3, 3, 0);
    send(3, 3, 0);
    idle(4);
    chk("prerst_sum_ed",     64'(sum_ed),     64'd18);
    chk("prerst_sample_cnt", 64'(sample_cnt), 64'd2);
    chk("prerst_busy",       64'(busy),       64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sample_cnt", 64'(sample_cnt),   64'd0);
    chk("midrst_err_cnt",    64'(err_cnt),      64'd0);
    chk("midrst_sum_ed",     64'(sum_ed),       64'd0);
    chk("midrst_max_ed",     64'(max_ed),       64'd0);
    chk("midrst_busy",       64'(busy),         64'd0);
    chk("midrst_in_ready",   64'(smp.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1, 1, 4, 4, 4, 4);
    start_run(1);
    send(4, 4, 20);
    wait_done("after_rst");

    // Gapped input, ignored start during RUN, in_valid held past the count
    push_exp(3, 2, 2, 1, 7, 7);
    start_run(3);
    send(5, 6, 30);
    idle(2);
    send(7, 7, 50);
    @(negedge clk);
    num_samples = CNT_W'(10);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    chk("run_start_ignored_cnt", 64'(sample_cnt), 64'd2);
    idle(1);
    send(9, 9, 80);
    smp.in_valid  = 1'b1;
    smp.in_a      = WIDTH'(100);
    smp.in_b      = WIDTH'(100);
    smp.in_approx = '0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (smp.in_ready) rdy_seen = 1'b1;
    end
    chk("hold_in_ready_low",  64'(rdy_seen),   64'd0);
    chk("hold_no_extra_cnt",  64'(sample_cnt), 64'd3);
    smp.in_valid = 1'b0;
    wait_done("gapped");
    idle(3);
    chk("done_hold_sum_ed",   64'(sum_ed), 64'd2);
    chk("done_level",         64'(done),   64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
